// File: rtl/nibble_serializer.sv
// Purpose: frames a 4-bit word as start + 4 data bits (LSB first) + stop on one serial line.
// Latency: line drops to the start bit the cycle after an accept from idle; frame is 6*BIT_CYCLES cycles.
// Backpressure: one-entry hold register; ready falls while it is occupied, enable is ignored then.
module nibble_serializer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] Inp,
    output logic       ready,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] sr;
    logic [3:0] sr_n;
    logic [3:0] hold;
    logic [3:0] hold_n;
    logic       hold_full;
    logic       hold_full_n;
    logic [7:0] cyc_cnt;
    logic [7:0] cyc_n;
    logic [1:0] bit_idx;
    logic [1:0] bit_idx_n;
    logic       line_n;
    logic       busy_n;
    logic       done_n;
    logic       accept;
    logic       bit_end;

    assign ready   = !hold_full && !rst;
    assign accept  = enable && ready;
    assign bit_end = (cyc_cnt == LAST);

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_n     = state;
        sr_n        = sr;
        hold_n      = hold;
        hold_full_n = hold_full;
        cyc_n       = cyc_cnt;
        bit_idx_n   = bit_idx;

        // Bit-period counter free-runs while a frame is on the line.
        if (state != IDLE) begin
            cyc_n = bit_end ? 8'd0 : cyc_cnt + 8'd1;
        end

        // Mid-frame accept parks the nibble; the stop-bit bypass below may override it.
        if ((state != IDLE) && accept) begin
            hold_n      = Inp;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    sr_n    = Inp;
                    cyc_n   = 8'd0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_n = 2'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sr_n = {1'b0, sr[3:1]};
                    if (bit_idx == 2'd3) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 2'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full) begin
                        sr_n        = hold;
                        hold_full_n = 1'b0;
                        state_n     = START;
                    end else if (accept) begin
                        // Same-edge accept goes straight to the shifter, hold stays empty.
                        sr_n        = Inp;
                        hold_full_n = 1'b0;
                        state_n     = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so derive them from the upcoming state.
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = sr_n[0];
            default: line_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (cyc_n == LAST);
    end

    // Control state and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            hold_full  <= 1'b0;
            cyc_cnt    <= 8'd0;
            bit_idx    <= 2'd0;
        end else begin
            state      <= state_n;
            serial_out <= line_n;
            busy       <= busy_n;
            done       <= done_n;
            hold_full  <= hold_full_n;
            cyc_cnt    <= cyc_n;
            bit_idx    <= bit_idx_n;
        end
    end

    // Data registers need no reset; their contents only matter once a frame is loaded.
    always_ff @(posedge clk) begin
        sr   <= sr_n;
        hold <= hold_n;
    end

endmodule
